// File: rtl/trumpet_oscillator.sv
// Trumpet phase generator: plays the FRONT (attack) table once, then loops BACK until released.
// Optional build macro TRUMPET_LEGATO_EN: note_on while in BACK keeps the loop running (legato).
package trumpet_oscillator_pkg;
    typedef enum logic {FRONT = 1'b0, BACK = 1'b1} oscillator_state_t;
endpackage

module trumpet_oscillator
    import trumpet_oscillator_pkg::*;
#(
    parameter int PHASE_WIDTH = 10,
    parameter int FRAC_WIDTH  = 22,
    parameter int INC_WIDTH   = PHASE_WIDTH + FRAC_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   sample_tick,
    input  logic                   note_on,
    input  logic                   note_off,
    input  logic [INC_WIDTH-1:0]   increment,
    output logic [PHASE_WIDTH-1:0] phase,
    output oscillator_state_t      state,
    output logic                   active,
    output logic                   front_done
);
    localparam int ACC  = PHASE_WIDTH + FRAC_WIDTH;
    localparam int ACC1 = ACC + 1;

    typedef enum logic [1:0] {S_IDLE, S_FRONT, S_BACK} fsm_t;

    fsm_t           fsm, fsm_next;
    logic [ACC-1:0] acc, acc_next;
    logic [ACC:0]   sum;
    logic           front_done_next;

    // Top bit of the widened sum is the wrap flag.
    assign sum   = {1'b0, acc} + ACC1'(increment);
    assign phase = acc[ACC-1:FRAC_WIDTH];

    always_comb begin
        fsm_next        = fsm;
        acc_next        = acc;
        front_done_next = 1'b0;
        case (fsm)
            S_IDLE: begin
                acc_next = '0;
                if (note_on) fsm_next = S_FRONT;
            end
            S_FRONT: begin
                if (note_on) begin
                    acc_next = '0;
                end else if (note_off) begin
                    fsm_next = S_IDLE;
                    acc_next = '0;
                end else if (sample_tick) begin
                    acc_next = sum[ACC-1:0];
                    if (sum[ACC]) begin
                        fsm_next        = S_BACK;
                        front_done_next = 1'b1;
                    end
                end
            end
            S_BACK: begin
                if (note_on) begin
`ifdef TRUMPET_LEGATO_EN
                    // Legato: hold the loop position; the tick in this cycle is dropped.
                    fsm_next = S_BACK;
`else
                    fsm_next = S_FRONT;
                    acc_next = '0;
`endif
                end else if (note_off) begin
                    fsm_next = S_IDLE;
                    acc_next = '0;
                end else if (sample_tick) begin
                    acc_next = sum[ACC-1:0];
                end
            end
            default: begin
                fsm_next = S_IDLE;
                acc_next = '0;
            end
        endcase
    end

    // state/active lag the FSM by one clock to line up with the downstream LUT register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm        <= S_IDLE;
            acc        <= '0;
            front_done <= 1'b0;
            state      <= FRONT;
            active     <= 1'b0;
        end else begin
            fsm        <= fsm_next;
            acc        <= acc_next;
            front_done <= front_done_next;
            state      <= (fsm == S_BACK) ? BACK : FRONT;
            active     <= (fsm != S_IDLE);
        end
    end
endmodule

// File: tb/tb_trumpet_oscillator.sv
// Directed self-checking bench for trumpet_oscillator (PHASE_WIDTH=10, FRAC_WIDTH=22).
module tb_trumpet_oscillator;
    import trumpet_oscillator_pkg::*;

    logic              clock;
    logic              reset_n;
    logic              sample_tick;
    logic              note_on;
    logic              note_off;
    logic [31:0]       increment;
    logic [9:0]        phase;
    oscillator_state_t state;
    logic              active;
    logic              front_done;

    int passed = 0;
    int total  = 0;

    trumpet_oscillator #(.PHASE_WIDTH(10), .FRAC_WIDTH(22)) dut (
        .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
        .note_on(note_on), .note_off(note_off), .increment(increment),
        .phase(phase), .state(state), .active(active), .front_done(front_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of controls, then sample 1 time unit after the edge.
    task automatic step(input logic on, input logic off, input logic tk);
        note_on = on; note_off = off; sample_tick = tk;
        @(posedge clock); #1;
        note_on = 1'b0; note_off = 1'b0; sample_tick = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b1; note_on = 0; note_off = 0; sample_tick = 0; increment = '0;
        #2 reset_n = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        total++; if (phase !== 10'd0) $display("FAIL reset_phase got %0d want 0", phase); else passed++;
        total++; if (state !== FRONT) $display("FAIL reset_state got %0d want FRONT", state); else passed++;
        total++; if (active !== 1'b0) $display("FAIL reset_active got %b want 0", active); else passed++;
        total++; if (front_done !== 1'b0) $display("FAIL reset_front_done got %b want 0", front_done); else passed++;
        reset_n = 1'b1;
        step(0, 0, 1);
        total++; if (active !== 1'b0 || phase !== 10'd0) $display("FAIL reset_idle got active=%b phase=%0d want 0/0", active, phase); else passed++;
    endtask

    task automatic test_front_sweep;
        increment = 32'h0040_0000;
        step(1, 0, 0);
        total++; if (phase !== 10'd0) $display("FAIL sweep_start_phase got %0d want 0", phase); else passed++;
        for (int i = 1; i <= 1024; i++) begin
            step(0, 0, 1);
            total++; if (phase !== 10'(i % 1024)) $display("FAIL sweep_phase i=%0d got %0d want %0d", i, phase, i % 1024); else passed++;
            total++; if (front_done !== (i == 1024)) $display("FAIL sweep_front_done i=%0d got %b want %b", i, front_done, (i == 1024)); else passed++;
            total++; if (state !== FRONT || active !== 1'b1) $display("FAIL sweep_state i=%0d got state=%0d active=%b want FRONT/1", i, state, active); else passed++;
        end
        step(0, 0, 0);
        total++; if (state !== BACK) $display("FAIL sweep_state_back got %0d want BACK", state); else passed++;
        total++; if (front_done !== 1'b0) $display("FAIL sweep_fd_clear got %b want 0", front_done); else passed++;
    endtask

    task automatic test_fractional_loop;
        increment = 32'h0060_0000;
        for (int n = 1; n <= 700; n++) begin
            step(0, 0, 1);
            total++; if (phase !== 10'((3 * n / 2) % 1024)) $display("FAIL frac_phase n=%0d got %0d want %0d", n, phase, (3 * n / 2) % 1024); else passed++;
            total++; if (state !== BACK || front_done !== 1'b0) $display("FAIL frac_state n=%0d got state=%0d fd=%b want BACK/0", n, state, front_done); else passed++;
        end
    endtask

    task automatic test_release;
        step(0, 1, 0);
        total++; if (phase !== 10'd0) $display("FAIL release_phase got %0d want 0", phase); else passed++;
        total++; if (active !== 1'b1) $display("FAIL release_active_lag got %b want 1", active); else passed++;
        step(0, 0, 1);
        total++; if (active !== 1'b0) $display("FAIL release_active got %b want 0", active); else passed++;
        total++; if (state !== FRONT || phase !== 10'd0) $display("FAIL release_idle got state=%0d phase=%0d want FRONT/0", state, phase); else passed++;
    endtask

    task automatic test_priority;
        increment = 32'h0040_0000;
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        total++; if (phase !== 10'd5) $display("FAIL prio_pre_phase got %0d want 5", phase); else passed++;
        step(1, 1, 1);
        total++; if (phase !== 10'd0) $display("FAIL prio_phase got %0d want 0", phase); else passed++;
        step(0, 0, 0);
        total++; if (active !== 1'b1 || state !== FRONT) $display("FAIL prio_active got active=%b state=%0d want 1/FRONT", active, state); else passed++;
    endtask

    task automatic test_retrigger;
        increment = 32'hFFC0_0000;
        step(0, 0, 1);
        total++; if (phase !== 10'd1023 || front_done !== 1'b0) $display("FAIL retrig_big1 got phase=%0d fd=%b want 1023/0", phase, front_done); else passed++;
        step(0, 0, 1);
        total++; if (phase !== 10'd1022 || front_done !== 1'b1) $display("FAIL retrig_big2 got phase=%0d fd=%b want 1022/1", phase, front_done); else passed++;
        increment = 32'h7D80_0000;
        step(0, 0, 1);
        total++; if (phase !== 10'd500) $display("FAIL retrig_pos got %0d want 500", phase); else passed++;
        increment = 32'h0040_0000;
        step(1, 0, 1);
`ifdef TRUMPET_LEGATO_EN
        total++; if (phase !== 10'd500) $display("FAIL retrig_phase got %0d want 500", phase); else passed++;
        step(0, 0, 1);
        total++; if (phase !== 10'd501 || state !== BACK) $display("FAIL retrig_next got phase=%0d state=%0d want 501/BACK", phase, state); else passed++;
`else
        total++; if (phase !== 10'd0) $display("FAIL retrig_phase got %0d want 0", phase); else passed++;
        step(0, 0, 1);
        total++; if (phase !== 10'd1 || state !== FRONT) $display("FAIL retrig_next got phase=%0d state=%0d want 1/FRONT", phase, state); else passed++;
`endif
    endtask

    task automatic test_zero_increment;
        step(0, 1, 0);
        step(1, 0, 0);
        increment = 32'h0040_0000;
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        total++; if (phase !== 10'd3) $display("FAIL zero_pre got %0d want 3", phase); else passed++;
        increment = '0;
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 1);
            total++; if (phase !== 10'd3 || state !== FRONT || front_done !== 1'b0) $display("FAIL zero_inc i=%0d got phase=%0d state=%0d fd=%b want 3/FRONT/0", i, phase, state, front_done); else passed++;
        end
        increment = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            total++; if (phase !== 10'd3) $display("FAIL no_tick i=%0d got %0d want 3", i, phase); else passed++;
        end
        step(0, 0, 1);
        total++; if (phase !== 10'd2 || front_done !== 1'b1) $display("FAIL max_inc got phase=%0d fd=%b want 2/1", phase, front_done); else passed++;
        step(0, 0, 0);
        total++; if (state !== BACK || front_done !== 1'b0) $display("FAIL max_inc_back got state=%0d fd=%b want BACK/0", state, front_done); else passed++;
    endtask

    task automatic test_reset_mid_note;
        total++; if (state !== BACK || active !== 1'b1) $display("FAIL mid_pre got state=%0d active=%b want BACK/1", state, active); else passed++;
        #3 reset_n = 1'b0;
        #1;
        total++; if (phase !== 10'd0) $display("FAIL mid_reset_phase got %0d want 0", phase); else passed++;
        total++; if (state !== FRONT) $display("FAIL mid_reset_state got %0d want FRONT", state); else passed++;
        total++; if (active !== 1'b0 || front_done !== 1'b0) $display("FAIL mid_reset_act got active=%b fd=%b want 0/0", active, front_done); else passed++;
        @(posedge clock); #1;
        reset_n = 1'b1;
        increment = 32'h0040_0000;
        step(0, 0, 1);
        step(0, 0, 1);
        total++; if (phase !== 10'd0 || active !== 1'b0 || state !== FRONT) $display("FAIL mid_idle got phase=%0d active=%b state=%0d want 0/0/FRONT", phase, active, state); else passed++;
    endtask

    initial begin
        test_reset;
        test_front_sweep;
        test_fractional_loop;
        test_release;
        test_priority;
        test_retrigger;
        test_zero_increment;
        test_reset_mid_note;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/trumpet_oscillator.md
Name: trumpet_oscillator

Overview:
- Phase-generation stage directly upstream of the trumpet wavetable stage.
- Per voice, it produces the phase index into the wavetables and the segment selector (OSCILLATOR::FRONT / OSCILLATOR::BACK).
- On a trigger it plays the front (attack) table once, then loops the back (sustain) table until released.
- It advances only on sample ticks; the increment sets pitch.

Parameters:
- PHASE_WIDTH, CONFIG::LONG_PERCENT_WIDTH, integer phase bits (table index width).
- FRAC_WIDTH, 22, fractional accumulator bits below the table index.
- INC_WIDTH, PHASE_WIDTH+FRAC_WIDTH, width of the increment input (must be ≤ ACC width).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle pulse per audio sample; the accumulator advances only on this pulse.
- note_on  in  1  one-cycle trigger that starts or retriggers the note.
- note_off  in  1  one-cycle release that stops the note.
- increment  in  INC_WIDTH  phase step per sample, unsigned; sampled on every sample_tick.
- phase  out  PHASE_WIDTH  table index (CONFIG::long_percent_t) for the wavetable stage.
- state  out  OSCILLATOR::oscillator_state_t  segment select, delayed to match one-cycle LUT latency.
- active  out  1  high while the note sounds, also delay-aligned like state.
- front_done  out  1  one-cycle pulse when FRONT→BACK occurs (undelayed).

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset values: acc=0, FSM=IDLE, phase=0, state=FRONT, active=0, front_done=0.
- Accumulator: acc is ACC=PHASE_WIDTH+FRAC_WIDTH bits, unsigned.
  - phase = acc[ACC-1:FRAC_WIDTH], registered.
  - The sum is ACC+1 bits; the carry is the wrap flag.
  - The result wraps modulo 2^ACC and keeps the residual fraction.
- FSM states: IDLE, FRONT, BACK.
- IDLE:
  - acc held at 0.
  - note_on → FRONT with acc=0 on the next clock; no tick is needed.
- FRONT:
  - On tick, acc += increment.
  - Carry → BACK, with acc = wrapped sum, and front_done pulses the same cycle the register updates.
- BACK:
  - On tick, acc += increment.
  - Carry ignored (free loop).
- Release: note_off in FRONT or BACK → IDLE and acc=0 on the next clock.
- Priority: note_on beats note_off in the same cycle (retrigger wins). Both beat sample_tick.
- Retrigger: note_on in FRONT or BACK → FRONT, acc=0; the tick in that cycle is discarded.
- Zero increment: phase is frozen and the FSM does not advance; this is legal.
- Increment ≥ 2^ACC is impossible by width. Increment > 2^(ACC-1) may wrap every tick. FRONT still exits at the first carry.
- Alignment:
  - The downstream stage registers its LUT output one cycle after phase.
  - So state and active are FSM-state/active delayed by one clock through a register.
  - At the ports, phase of sample n and state of sample n-1 coexist for one cycle. This is intentional.
- Reset mid-note: all outputs return to reset values immediately (asynchronous), with no glitch pulse on front_done.
- Latency:
  - Tick → phase update: 1 cycle.
  - Tick → state/active update: 2 cycles.

Optional Feature:
- Macro: TRUMPET_LEGATO_EN.
- Defined:
  - note_on while in BACK keeps BACK and acc unchanged (legato); only the new increment takes effect.
  - note_on in IDLE or FRONT behaves as without the macro.
- Undefined: every note_on retriggers to FRONT with acc=0.

Test Plan (PHASE_WIDTH=10, FRAC_WIDTH=22):
- Reset: assert reset_n=0 mid-BACK → phase=0, state=FRONT, active=0, front_done=0 within the same cycle; FSM is IDLE after release.
- Linear front sweep: note_on, increment=0x0040_0000, 1024 ticks → phase steps 0..1023 one per tick; front_done pulses once after the 1024th tick; state becomes BACK one clock after the FSM does.
- Fractional loop: in BACK with increment=0x0060_0000 → phase sequence 0,1,3,4,6,…, and wrap from 1023 back to 0/1 without any FSM change.
- Release and priority:
  - note_off in BACK → active=0 two clocks later, phase=0.
  - note_on+note_off in the same cycle → FRONT, acc=0, active stays 1.
- Retrigger: note_on at phase=500 in BACK → phase=0, FRONT.
  - With TRUMPET_LEGATO_EN, phase continues 501… and state stays BACK.
- Zero increment and no ticks: increment=0 for 100 ticks → phase constant; ticks absent, increment=max → phase unchanged.
